bin2bcd_seq: RTL and testbench

Sequential binary-to-BCD converter (shift-and-add-3 / double-dabble) turning the binary results of the BCD/binary adder–subtractor datapath into decimal digits for display and checking. It sits downstream of the add/sub stage: it accepts one W-bit operand per request, unsigned or two's-complement, and after a fixed latency returns a sign flag plus D packed BCD digits. It uses a start/busy/done handshake and holds its result until the next conversion completes.

---
 rtl/bin2bcd_seq.sv | 104 ++++++++++
 tb/tb_bin2bcd_seq.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3), with optional two's-complement input.
// Start/busy/done handshake; bcd/neg are registered and hold until the next conversion completes.
module bin2bcd_seq #(
  parameter int unsigned W = 8,
  parameter int unsigned D = 3
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [W-1:0]   bin,
  input  logic           signed_mode,
  output logic           busy,
  output logic           done,
  output logic           neg,
  output logic [4*D-1:0] bcd
);

  localparam int unsigned CW   = $clog2(W + 1);
  localparam logic [CW-1:0] LAST = CW'(W - 1);
  localparam logic [CW-1:0] CONE = CW'(1);
  localparam logic [W-1:0]  WONE = W'(1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;

  state_e         state_q;
  logic [W-1:0]   mag_q;
  logic [4*D-1:0] dig_q;
  logic [CW-1:0]  cnt_q;
  logic           neg_next_q;
  logic           busy_q, done_q, neg_q;
  logic [4*D-1:0] bcd_q;

  logic           is_neg;
  logic [W-1:0]   mag_in;
  logic [4*D-1:0] dig_d;
  logic [3:0]     nib;
  logic           carry;

  assign is_neg = signed_mode && bin[W-1];
  assign mag_in = is_neg ? (~bin + WONE) : bin;

  // Adjust and shift in one pass: each digit's MSB after add-3 carries into the next digit.
  always_comb begin
    dig_d = '0;
    nib   = '0;
    carry = mag_q[W-1];
    for (int unsigned i = 0; i < D; i++) begin
      nib = dig_q[4*i +: 4];
      if (nib >= 4'd5) nib = nib + 4'd3;
      dig_d[4*i +: 4] = {nib[2:0], carry};
      carry = nib[3];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      mag_q      <= '0;
      dig_q      <= '0;
      cnt_q      <= '0;
      neg_next_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      neg_q      <= 1'b0;
      bcd_q      <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            mag_q      <= mag_in;
            neg_next_q <= is_neg;
            dig_q      <= '0;
            cnt_q      <= '0;
            busy_q     <= 1'b1;
            state_q    <= SHIFT;
          end
        end
        SHIFT: begin
          dig_q <= dig_d;
          mag_q <= {mag_q[W-2:0], 1'b0};
          cnt_q <= cnt_q + CONE;
          if (cnt_q == LAST) begin
            bcd_q   <= dig_d;
            neg_q   <= neg_next_q;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign neg  = neg_q;
  assign bcd  = bcd_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Scoreboard bench for bin2bcd_seq (W=8, D=3): expected {neg,bcd} queued at request, checked at done.
module tb_bin2bcd_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  bin = '0;
  logic        signed_mode = 1'b0;
  logic        busy, done, neg;
  logic [11:0] bcd;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_cnt = 0;
  logic [12:0] sb[$];

  bin2bcd_seq #(.W(8), .D(3)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .bin(bin),
    .signed_mode(signed_mode), .busy(busy), .done(done), .neg(neg), .bcd(bcd)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (done) done_cnt++;

  // Reference model: decimal arithmetic, independent of the shift-add algorithm.
  function automatic logic [12:0] model(input logic [7:0] b, input logic sm);
    int v;
    logic n;
    n = sm && b[7];
    v = n ? 256 - int'(b) : int'(b);
    model = {n, 4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Drives a request and returns the cycle stamp of the accepting edge.
  task automatic start_conv(input logic [7:0] b, input logic sm, output int acc);
    bin = b;
    signed_mode = sm;
    start = 1'b1;
    tick();
    acc = cyc;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output logic seen);
    seen = 1'b0;
    for (int k = 0; k < budget && !seen; k++) begin
      tick();
      if (done) seen = 1'b1;
    end
  endtask

  task automatic test_reset();
    int d0;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
    checks++; if (neg !== 1'b0) begin errors++; $display("FAIL reset_neg got %b want 0", neg); end
    checks++; if (bcd !== 12'h000) begin errors++; $display("FAIL reset_bcd got %h want 000", bcd); end
    d0 = done_cnt;
    repeat (6) tick();
    checks++; if (done_cnt !== d0) begin errors++; $display("FAIL idle_no_done got %0d want %0d", done_cnt, d0); end
  endtask

  task automatic test_unsigned();
    logic [7:0] vals[2] = '{8'd18, 8'd255};
    logic [12:0] exp;
    logic seen;
    int acc;
    foreach (vals[i]) begin
      sb.push_back(model(vals[i], 1'b0));
      start_conv(vals[i], 1'b0, acc);
      wait_done(20, seen);
      exp = sb.pop_front();
      checks++; if (!seen) begin errors++; $display("FAIL uns_timeout got none want done"); end
      checks++; if (cyc - acc !== 8) begin errors++; $display("FAIL uns_latency got %0d want 8", cyc - acc); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL uns_busy_at_done got %b want 1", busy); end
      checks++; if ({neg, bcd} !== exp) begin errors++; $display("FAIL uns_result got %b/%h want %b/%h", neg, bcd, exp[12], exp[11:0]); end
      tick();
      checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL uns_done_width got done=%b busy=%b want 0/0", done, busy); end
    end
  endtask

  task automatic test_signed();
    logic [7:0] vals[4] = '{8'hFC, 8'hFC, 8'h80, 8'h00};
    logic       sms[4]  = '{1'b1, 1'b0, 1'b1, 1'b1};
    logic [12:0] exp;
    logic seen;
    int acc;
    foreach (vals[i]) begin
      sb.push_back(model(vals[i], sms[i]));
      start_conv(vals[i], sms[i], acc);
      wait_done(20, seen);
      exp = sb.pop_front();
      checks++; if (!seen) begin errors++; $display("FAIL sgn_timeout idx %0d got none want done", i); end
      checks++; if ({neg, bcd} !== exp) begin errors++; $display("FAIL sgn_result idx %0d got %b/%h want %b/%h", i, neg, bcd, exp[12], exp[11:0]); end
      tick();
    end
  endtask

  task automatic test_busy_protect();
    logic [12:0] exp;
    logic seen;
    int acc, d0;
    d0 = done_cnt;
    sb.push_back(model(8'd14, 1'b0));
    start_conv(8'd14, 1'b0, acc);
    tick();
    bin = 8'd99; signed_mode = 1'b1; start = 1'b1;
    tick();
    start = 1'b0; bin = 8'hFF;
    tick();
    signed_mode = 1'b0; bin = 8'h81;
    wait_done(20, seen);
    exp = sb.pop_front();
    checks++; if (!seen) begin errors++; $display("FAIL busy_timeout got none want done"); end
    checks++; if (cyc - acc !== 8) begin errors++; $display("FAIL busy_latency got %0d want 8", cyc - acc); end
    checks++; if ({neg, bcd} !== exp) begin errors++; $display("FAIL busy_result got %b/%h want %b/%h", neg, bcd, exp[12], exp[11:0]); end
    repeat (15) tick();
    checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL busy_pulses got %0d want 1", done_cnt - d0); end
  endtask

  task automatic test_reset_mid();
    logic [12:0] exp;
    logic seen;
    int acc, d0;
    start_conv(8'd200, 1'b0, acc);
    repeat (3) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmid_busy got %b want 0", busy); end
    checks++; if (bcd !== 12'h000 || neg !== 1'b0) begin errors++; $display("FAIL rmid_outputs got %b/%h want 0/000", neg, bcd); end
    d0 = done_cnt;
    repeat (15) tick();
    checks++; if (done_cnt !== d0) begin errors++; $display("FAIL rmid_no_done got %0d want %0d", done_cnt, d0); end
    sb.push_back(model(8'd9, 1'b0));
    start_conv(8'd9, 1'b0, acc);
    wait_done(20, seen);
    exp = sb.pop_front();
    checks++; if (!seen || {neg, bcd} !== exp) begin errors++; $display("FAIL rmid_fresh got seen=%b %b/%h want %b/%h", seen, neg, bcd, exp[12], exp[11:0]); end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [7:0] vals[3] = '{8'd1, 8'd10, 8'd100};
    logic [12:0] exp;
    int t[3];
    int k = 0;
    bin = vals[0]; signed_mode = 1'b0; start = 1'b1;
    sb.push_back(model(vals[0], 1'b0));
    for (int n = 0; n < 60 && k < 3; n++) begin
      tick();
      if (done) begin
        t[k] = cyc;
        exp = sb.pop_front();
        checks++; if ({neg, bcd} !== exp) begin errors++; $display("FAIL b2b_result idx %0d got %b/%h want %b/%h", k, neg, bcd, exp[12], exp[11:0]); end
        k++;
        if (k < 3) begin
          bin = vals[k];
          sb.push_back(model(vals[k], 1'b0));
        end
      end
    end
    start = 1'b0;
    checks++; if (k !== 3) begin errors++; $display("FAIL b2b_count got %0d want 3", k); end
    if (k == 3) begin
      checks++; if (t[1] - t[0] !== 10) begin errors++; $display("FAIL b2b_gap1 got %0d want 10", t[1] - t[0]); end
      checks++; if (t[2] - t[1] !== 10) begin errors++; $display("FAIL b2b_gap2 got %0d want 10", t[2] - t[1]); end
    end
    repeat (3) tick();
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_busy_protect();
    test_reset_mid();
    test_back_to_back();
    checks++; if (sb.size() !== 0) begin errors++; $display("FAIL scoreboard_leftover got %0d want 0", sb.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
